// File: rtl/nn_if_pkg.sv
// nn_if_pkg: shared defaults, FSM state encoding and packed input word type for the inference driver
package nn_if_pkg;
    localparam int FEAT_W_DEF = 16;
    localparam int N_FEAT_DEF = 2;
    typedef enum logic [1:0] {GATHER, ISSUE, WAIT, DELIVER} state_t;
    typedef logic [N_FEAT_DEF*FEAT_W_DEF-1:0] in_word_t;
endpackage

// File: rtl/nn_infer_driver_if.sv
// nn_infer_driver_if: feature stream, result stream and ap_ctrl_hs/ap_vld core signals
interface nn_infer_driver_if
    import nn_if_pkg::*;
#(
    parameter int FEAT_W = FEAT_W_DEF,
    parameter int N_FEAT = N_FEAT_DEF
) ();
    logic [FEAT_W-1:0]        s_feat_data;
    logic                     s_feat_valid;
    logic                     s_feat_ready;
    logic [FEAT_W-1:0]        m_res_data;
    logic                     m_res_timeout;
    logic                     m_res_valid;
    logic                     m_res_ready;
    logic                     nn_ap_start;
    logic                     nn_ap_ready;
    logic                     nn_ap_done;
    logic                     nn_ap_idle;
    logic [N_FEAT*FEAT_W-1:0] nn_input_V;
    logic                     nn_input_V_ap_vld;
    logic [FEAT_W-1:0]        nn_out_V;
    logic                     nn_out_V_ap_vld;
    modport master (
        input  s_feat_data, s_feat_valid, m_res_ready, nn_ap_ready, nn_ap_done, nn_ap_idle,
               nn_out_V, nn_out_V_ap_vld,
        output s_feat_ready, m_res_data, m_res_timeout, m_res_valid, nn_ap_start, nn_input_V,
               nn_input_V_ap_vld
    );
    modport slave (
        output s_feat_data, s_feat_valid, m_res_ready, nn_ap_ready, nn_ap_done, nn_ap_idle,
               nn_out_V, nn_out_V_ap_vld,
        input  s_feat_ready, m_res_data, m_res_timeout, m_res_valid, nn_ap_start, nn_input_V,
               nn_input_V_ap_vld
    );
endinterface

// File: rtl/nn_feat_packer.sv
// nn_feat_packer: writes accepted features into consecutive slots of the core input word
module nn_feat_packer
    import nn_if_pkg::*;
#(
    parameter int FEAT_W = FEAT_W_DEF,
    parameter int N_FEAT = N_FEAT_DEF
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     accept,
    input  logic [FEAT_W-1:0]        feat,
    output logic [N_FEAT*FEAT_W-1:0] word,
    output logic                     full,
    output logic                     held
);
    localparam int IDX_W = N_FEAT > 1 ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FEAT - 1);
    logic [IDX_W-1:0] idx;
    assign full = accept && idx == LAST;
    assign held = idx != '0;
    // store each accepted feature in its slot, wrapping the index after the last slot
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            idx  <= '0;
            word <= '0;
        end else if (accept) begin
            word[idx*FEAT_W +: FEAT_W] <= feat;
            idx <= full ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/nn_infer_driver.sv
// nn_infer_driver: gathers features, runs one ap_ctrl_hs inference and returns the result or a timeout
module nn_infer_driver
    import nn_if_pkg::*;
#(
    parameter int FEAT_W  = FEAT_W_DEF,
    parameter int N_FEAT  = N_FEAT_DEF,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    nn_infer_driver_if.master bus,
    output logic            busy,
    output logic [TO_W-1:0] err_count
);
    state_t state, state_nx;
    logic [TO_W-1:0] cnt;
    logic [FEAT_W-1:0] res_data;
    logic res_to, accept, full, held, hs, got, expire;
    assign accept = bus.s_feat_valid && bus.s_feat_ready;
    assign hs     = state == ISSUE && bus.nn_ap_ready;
    assign got    = (hs || state == WAIT) && bus.nn_out_V_ap_vld;
    assign expire = state == WAIT && !bus.nn_out_V_ap_vld && cnt == TO_W'(TIMEOUT - 1);
    assign bus.s_feat_ready      = state == GATHER;
    assign bus.nn_ap_start       = state == ISSUE;
    assign bus.nn_input_V_ap_vld = state == ISSUE;
    assign bus.m_res_valid       = state == DELIVER;
    assign bus.m_res_data        = res_data;
    assign bus.m_res_timeout     = res_to;
    assign busy = state != GATHER || held;
    nn_feat_packer #(.FEAT_W(FEAT_W), .N_FEAT(N_FEAT)) u_packer (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .accept   (accept),
        .feat     (bus.s_feat_data),
        .word     (bus.nn_input_V),
        .full     (full),
        .held     (held)
    );
    // next state: a result captured in the handshake cycle skips WAIT
    always_comb begin
        state_nx = state;
        case (state)
            GATHER:  state_nx = full ? ISSUE : GATHER;
            ISSUE:   state_nx = !hs ? ISSUE : got ? DELIVER : WAIT;
            WAIT:    state_nx = (got || expire) ? DELIVER : WAIT;
            DELIVER: state_nx = bus.m_res_ready ? GATHER : DELIVER;
            default: state_nx = GATHER;
        endcase
    end
    // state, wait counter, result register and saturating timeout count
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state     <= GATHER;
            cnt       <= '0;
            res_data  <= '0;
            res_to    <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_nx;
            cnt   <= state == WAIT ? cnt + 1'b1 : '0;
            if (got) begin
                res_data <= bus.nn_out_V;
                res_to   <= 1'b0;
            end else if (expire) begin
                res_data  <= '0;
                res_to    <= 1'b1;
                err_count <= err_count + TO_W'(err_count != '1);
            end
        end
    end
endmodule

// File: tb/tb_nn_infer_driver.sv
// tb_nn_infer_driver: randomized scoreboard bench with a behavioural dense-layer core
module tb_nn_infer_driver;
    import nn_if_pkg::*;
    localparam int TIMEOUT = 255;
    typedef struct {
        logic        to;
        logic [15:0] data;
        int          lat;
    } exp_t;
    logic ap_clk = 1'b0;
    logic ap_rst_n;
    logic busy;
    logic [7:0] err_count;
    nn_infer_driver_if #(.FEAT_W(16), .N_FEAT(2)) bus ();
    nn_infer_driver #(.FEAT_W(16), .N_FEAT(2), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .bus       (bus),
        .busy      (busy),
        .err_count (err_count)
    );
    always #5 ap_clk = ~ap_clk;
    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int res_cnt = 0;
    int exp_err = 0;
    int ready_delay = 0;
    bit core_dead = 0;
    bit fast = 0;
    bit spur = 0;
    logic [15:0] feed_q[$];
    in_word_t    word_q[$];
    exp_t        exp_q[$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask
    function automatic logic [15:0] model(input logic signed [15:0] a, input logic signed [15:0] b);
        int acc;
        acc = -288 * int'(a) + 304 * int'(b);
        return 16'((acc >>> 10) + 157);
    endfunction
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        feed_q.push_back(a);
        feed_q.push_back(b);
        word_q.push_back({b, a});
        e.to   = core_dead;
        e.data = core_dead ? 16'h0 : model(a, b);
        e.lat  = core_dead ? TIMEOUT : fast ? 0 : 1;
        exp_q.push_back(e);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask
    task automatic drain(input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || feed_q.size() != 0) && i < budget) begin
            @(posedge ap_clk);
            i++;
        end
        #1;
        chk("drain_left", exp_q.size(), 0);
    endtask
    task automatic check_reset_vals();
        chk("rst_res_valid", bus.m_res_valid, 0);
        chk("rst_res_data", bus.m_res_data, 0);
        chk("rst_res_to", bus.m_res_timeout, 0);
        chk("rst_start", bus.nn_ap_start, 0);
        chk("rst_in_vld", bus.nn_input_V_ap_vld, 0);
        chk("rst_in_word", bus.nn_input_V, 0);
        chk("rst_err", err_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_feat_ready", bus.s_feat_ready, 1);
    endtask
    task automatic do_reset();
        ap_rst_n = 1'b0;
        feed_q.delete();
        word_q.delete();
        exp_q.delete();
        exp_err = 0;
        tick(2);
        @(negedge ap_clk);
        check_reset_vals();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask
    // upstream feeder: valid stays high while features are queued
    initial begin
        bit acc;
        bus.s_feat_valid = 1'b0;
        bus.s_feat_data  = '0;
        forever begin
            @(negedge ap_clk);
            acc = ap_rst_n && bus.s_feat_valid && bus.s_feat_ready;
            @(posedge ap_clk);
            #1;
            if (acc && feed_q.size() != 0) void'(feed_q.pop_front());
            bus.s_feat_valid = feed_q.size() != 0;
            bus.s_feat_data  = feed_q.size() != 0 ? feed_q[0] : 16'h0;
        end
    end
    // behavioural core: ap_ready after ready_delay cycles, result vld one cycle later
    initial begin
        int rd_wait = 0;
        logic [15:0] res;
        bus.nn_ap_ready = 1'b0;
        bus.nn_ap_done = 1'b0;
        bus.nn_ap_idle = 1'b1;
        bus.nn_out_V = '0;
        bus.nn_out_V_ap_vld = 1'b0;
        res = '0;
        forever begin
            @(posedge ap_clk);
            #1;
            bus.nn_out_V_ap_vld = 1'b0;
            bus.nn_ap_done = 1'b0;
            if (!ap_rst_n) begin
                bus.nn_ap_ready = 1'b0;
                rd_wait = 0;
            end else if (bus.nn_ap_ready) begin
                bus.nn_ap_ready = 1'b0;
                rd_wait = 0;
                if (!core_dead && !fast) begin
                    bus.nn_out_V_ap_vld = 1'b1;
                    bus.nn_out_V = res;
                    bus.nn_ap_done = 1'b1;
                end
            end else if (bus.nn_ap_start) begin
                if (rd_wait >= ready_delay) begin
                    bus.nn_ap_ready = 1'b1;
                    res = model(bus.nn_input_V[15:0], bus.nn_input_V[31:16]);
                    if (fast && !core_dead) begin
                        bus.nn_out_V_ap_vld = 1'b1;
                        bus.nn_out_V = res;
                    end
                end else begin
                    rd_wait++;
                end
            end else if (spur && (bus.s_feat_ready || bus.m_res_valid)) begin
                bus.nn_out_V_ap_vld = 1'b1;
                bus.nn_out_V = 16'hDEAD;
            end
        end
    end
    // monitor and scoreboard, sampled on the falling edge
    initial begin
        int lat = 0;
        int last_lat = 0;
        int issue_len = 0;
        int acc_n = 0;
        bit tracking = 0;
        bit exp_start = 0;
        exp_t e;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                tracking = 0;
                issue_len = 0;
                acc_n = 0;
                exp_start = 0;
                continue;
            end
            if (exp_start) chk("start_lat", bus.nn_ap_start, 1);
            exp_start = 0;
            if (bus.s_feat_valid && bus.s_feat_ready) begin
                acc_n++;
                exp_start = acc_n % 2 == 0;
            end
            if (bus.nn_ap_start) begin
                issue_len++;
                chk("issue_vld", bus.nn_input_V_ap_vld, 1);
                if (word_q.size() != 0) chk("issue_word", bus.nn_input_V, word_q[0]);
                else chk("spurious_start", bus.nn_ap_start, 0);
            end
            if (bus.nn_ap_start && bus.nn_ap_ready) begin
                hs_cnt++;
                chk("issue_len", issue_len, ready_delay + 1);
                if (word_q.size() != 0) void'(word_q.pop_front());
                issue_len = 0;
                tracking = 1;
                lat = 0;
            end else if (tracking) begin
                if (bus.m_res_valid) begin
                    tracking = 0;
                    last_lat = lat;
                end else begin
                    lat++;
                end
            end
            if (bus.m_res_valid && bus.m_res_ready) begin
                res_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", bus.m_res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.to) exp_err = exp_err == 255 ? 255 : exp_err + 1;
                    chk("res_data", bus.m_res_data, e.data);
                    chk("res_timeout", bus.m_res_timeout, e.to);
                    chk("res_latency", last_lat, e.lat);
                    chk("err_count", err_count, exp_err);
                end
            end
        end
    end
    // directed scenarios with randomized features
    initial begin
        int h;
        int n;
        logic [15:0] bp_exp;
        ap_rst_n = 1'b0;
        bus.m_res_ready = 1'b1;
        tick(3);
        @(negedge ap_clk);
        check_reset_vals();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        push_pair(16'd1024, 16'd1024);
        drain(100);
        chk("basic_hs", hs_cnt, 1);
        bus.m_res_ready = 1'b0;
        bp_exp = model(16'hFC00, 16'd2048);
        push_pair(16'hFC00, 16'd2048);
        push_pair(16'($urandom), 16'($urandom));
        n = 0;
        while (!bus.m_res_valid && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        repeat (10) begin
            @(negedge ap_clk);
            chk("bp_valid", bus.m_res_valid, 1);
            chk("bp_data", bus.m_res_data, bp_exp);
            chk("bp_feat_ready", bus.s_feat_ready, 0);
        end
        @(posedge ap_clk);
        #1;
        bus.m_res_ready = 1'b1;
        drain(200);
        ready_delay = 5;
        h = hs_cnt;
        push_pair(16'($urandom), 16'($urandom));
        drain(200);
        chk("delay_hs", hs_cnt - h, 1);
        ready_delay = 0;
        fast = 1;
        push_pair(16'($urandom), 16'($urandom));
        drain(100);
        fast = 0;
        core_dead = 1;
        h = hs_cnt;
        push_pair(16'($urandom), 16'($urandom));
        n = 0;
        while (hs_cnt == h && n < 100) begin
            tick(1);
            n++;
        end
        tick(10);
        chk("busy_wait", busy, 1);
        do_reset();
        core_dead = 0;
        push_pair(16'($urandom), 16'($urandom));
        drain(100);
        feed_q.push_back(16'($urandom));
        n = 0;
        while (feed_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(1);
        chk("busy_gather", busy, 1);
        do_reset();
        push_pair(16'h8000, 16'h7FFF);
        drain(100);
        spur = 1;
        n = res_cnt;
        repeat (20) push_pair(16'($urandom), 16'($urandom));
        drain(2000);
        chk("stream_count", res_cnt - n, 20);
        spur = 0;
        core_dead = 1;
        push_pair(16'($urandom), 16'($urandom));
        drain(400);
        chk("first_timeout_err", err_count, 1);
        repeat (256) push_pair(16'($urandom), 16'($urandom));
        drain(70000);
        chk("err_saturated", err_count, 255);
        core_dead = 0;
        push_pair(16'($urandom), 16'($urandom));
        drain(100);
        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
